// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the pipeline hazard controller.
//   - NREG_BITS / PC_REG : register tag width and program-counter tag
//   - tag_t              : register tag
//   - fwd_sel_e          : E-stage operand mux select encoding
//   - stage_tag_t        : per-stage destination/control shadow record
//   - tagHit()           : "this stage will write the register I read"

package hazard_pkg;

    localparam int NREG_BITS = 4;
    localparam int PC_REG    = 15;

    typedef logic [NREG_BITS-1:0] tag_t;

    localparam tag_t PC_TAG = tag_t'(PC_REG);

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        tag_t rd;
        logic regwrite;
        logic memtoreg;
        logic pcs;
    } stage_tag_t;

    // A write to the PC is a control transfer, never a data result, so it
    // must never count as a producer for forwarding or RAW detection.
    function automatic logic tagHit(tag_t src, stage_tag_t st);
        return st.regwrite && (st.rd != PC_TAG) && (st.rd == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel
//   Forward select for a single E-stage source operand.
//   Ports:
//     srcTag  : E-stage source register tag
//     useSrc  : E instruction actually reads srcTag
//     stageM  : M-stage shadow record
//     stageW  : W-stage shadow record
//     fwdSel  : FWD_M / FWD_W / FWD_RF

module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  tag_t       srcTag,
    input  logic       useSrc,
    input  stage_tag_t stageM,
    input  stage_tag_t stageW,
    output fwd_sel_e   fwdSel
);

    logic unusedFields;

    assign unusedFields = ^{stageM.memtoreg, stageM.pcs, stageW.memtoreg, stageW.pcs};

    // The younger producer (M) wins when both M and W write the same register.
    always_comb begin
        fwdSel = FWD_RF;
        if (useSrc && tagHit(srcTag, stageM)) begin
            fwdSel = FWD_M;
        end else if (useSrc && tagHit(srcTag, stageW)) begin
            fwdSel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for the 5-stage pipelined ARM core.
//   Tracks a shadow pipeline of E/M/W destination and source tags and
//   produces operand forward selects, fetch/decode stalls and D/E flushes.
//
//   Build option HAZARD_FWD_EN:
//     defined   : M/W results are forwarded to E; only load-use stalls.
//     undefined : forwardAE/forwardBE stay 00; any D source produced by
//                 E or M stalls until the producer reaches W.
//
//   Ports:
//     clk, reset           : core clock, synchronous active-high reset
//     RA1D, RA2D           : D-stage source tags
//     UseA1D, UseA2D       : D instruction reads RA1D / RA2D
//     RdD, RegWriteD       : D-stage destination tag and write enable
//     MemtoRegD            : D instruction is a load
//     PCSrcD               : D instruction writes the PC
//     BranchTakenE         : E-stage branch resolved taken
//     forwardAE, forwardBE : 00 register file, 01 ResultW, 10 ALUResultM
//     StallF, StallD       : hold PC / hold F-D register
//     FlushD, FlushE       : clear F-D / D-E register

module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREG_BITS-1:0] RA1D,
    input  logic [NREG_BITS-1:0] RA2D,
    input  logic                 UseA1D,
    input  logic                 UseA2D,
    input  logic [NREG_BITS-1:0] RdD,
    input  logic                 RegWriteD,
    input  logic                 MemtoRegD,
    input  logic                 PCSrcD,
    input  logic                 BranchTakenE,
    output logic [1:0]           forwardAE,
    output logic [1:0]           forwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE
);

    stage_tag_t stageE;
    stage_tag_t stageM;
    stage_tag_t stageW;
    tag_t       ra1E;
    tag_t       ra2E;
    logic       useA1E;
    logic       useA2E;

    fwd_sel_e   fwdA;
    fwd_sel_e   fwdB;
    fwd_sel_e   fwdSelA;
    fwd_sel_e   fwdSelB;
    logic       hazStall;
    logic       pcWrPending;
    logic       flushEInt;
    logic       unusedBits;

    hazard_fwd_sel uFwdA (
        .srcTag (ra1E),
        .useSrc (useA1E),
        .stageM (stageM),
        .stageW (stageW),
        .fwdSel (fwdA)
    );

    hazard_fwd_sel uFwdB (
        .srcTag (ra2E),
        .useSrc (useA2E),
        .stageM (stageM),
        .stageW (stageW),
        .fwdSel (fwdB)
    );

`ifdef HAZARD_FWD_EN
    // Only a load in E cannot be forwarded in time for the D instruction.
    assign hazStall = stageE.memtoreg &&
                      ((UseA1D && tagHit(RA1D, stageE)) ||
                       (UseA2D && tagHit(RA2D, stageE)));
    assign fwdSelA    = fwdA;
    assign fwdSelB    = fwdB;
    assign unusedBits = stageW.memtoreg;
`else
    // Without forwarding, D waits until its producer has left M; the register
    // file writes on the falling edge, so a W producer is already visible.
    assign hazStall = (UseA1D && (tagHit(RA1D, stageE) || tagHit(RA1D, stageM))) ||
                      (UseA2D && (tagHit(RA2D, stageE) || tagHit(RA2D, stageM)));
    assign fwdSelA    = FWD_RF;
    assign fwdSelB    = FWD_RF;
    assign unusedBits = ^{stageW.memtoreg, fwdA, fwdB};
`endif

    assign pcWrPending = PCSrcD | stageE.pcs | stageM.pcs;
    assign flushEInt   = hazStall | BranchTakenE;

    // Control outputs; reset overrides everything so the pipe registers are
    // flushed and nothing is held while the core comes out of reset.
    always_comb begin
        forwardAE = fwdSelA;
        forwardBE = fwdSelB;
        StallD    = hazStall;
        StallF    = hazStall | pcWrPending;
        FlushE    = flushEInt;
        FlushD    = pcWrPending | stageW.pcs | BranchTakenE;
        if (reset) begin
            forwardAE = FWD_RF;
            forwardBE = FWD_RF;
            StallD    = 1'b0;
            StallF    = 1'b0;
            FlushE    = 1'b1;
            FlushD    = 1'b1;
        end
    end

    // Shadow pipeline. A stalled D instruction is not copied into E: E takes
    // a bubble instead, so a held PCSrcD is only counted once it really issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            stageE <= '0;
            stageM <= '0;
            stageW <= '0;
            ra1E   <= '0;
            ra2E   <= '0;
            useA1E <= 1'b0;
            useA2E <= 1'b0;
        end else begin
            stageW <= stageM;
            stageM <= stageE;
            if (flushEInt) begin
                stageE <= '0;
                ra1E   <= '0;
                ra2E   <= '0;
                useA1E <= 1'b0;
                useA2E <= 1'b0;
            end else begin
                stageE <= '{rd: RdD, regwrite: RegWriteD, memtoreg: MemtoRegD, pcs: PCSrcD};
                ra1E   <= RA1D;
                ra2E   <= RA2D;
                useA1E <= UseA1D;
                useA2E <= UseA2D;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed-vector bench for hazard_ctrl. Each cycle drives one D-stage
//   instruction (plus reset / BranchTakenE) and compares the packed output
//   vector {forwardAE, forwardBE, StallF, StallD, FlushD, FlushE} against a
//   hand-derived value. Expectations follow the HAZARD_FWD_EN build option.

module tb_hazard_ctrl;

    localparam logic [7:0] E_NONE  = 8'h00;
    localparam logic [7:0] E_STALL = 8'h0D;
    localparam logic [7:0] E_PCW   = 8'h0A;
    localparam logic [7:0] E_FD    = 8'h02;
    localparam logic [7:0] E_FLUSH = 8'h03;
    localparam logic [7:0] E_ALL   = 8'h0F;
    localparam logic [7:0] E_AM    = 8'h80;
    localparam logic [7:0] E_AW    = 8'h40;
    localparam logic [7:0] E_BM    = 8'h20;
    localparam logic [7:0] E_BW    = 8'h10;

    typedef struct packed {
        logic       rst;
        logic       bt;
        logic [3:0] rd;
        logic       rw;
        logic       m2r;
        logic       pcs;
        logic [3:0] ra1;
        logic       u1;
        logic [3:0] ra2;
        logic       u2;
        logic [7:0] want;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic       UseA1D;
    logic       UseA2D;
    logic [3:0] RdD;
    logic       RegWriteD;
    logic       MemtoRegD;
    logic       PCSrcD;
    logic       BranchTakenE;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic [7:0] obs;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .UseA1D       (UseA1D),
        .UseA2D       (UseA2D),
        .RdD          (RdD),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .BranchTakenE (BranchTakenE),
        .forwardAE    (forwardAE),
        .forwardBE    (forwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE)
    );

    assign obs = {forwardAE, forwardBE, StallF, StallD, FlushD, FlushE};

    // Free-running core clock, period 10.
    always #5 clk = ~clk;

    // Hard stop in case a task never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic vec_t mk(logic rst, logic bt, logic [3:0] rd, logic rw, logic m2r,
                                logic pcs, logic [3:0] ra1, logic u1, logic [3:0] ra2,
                                logic u2, logic [7:0] want);
        vec_t v;
        v.rst  = rst;
        v.bt   = bt;
        v.rd   = rd;
        v.rw   = rw;
        v.m2r  = m2r;
        v.pcs  = pcs;
        v.ra1  = ra1;
        v.u1   = u1;
        v.ra2  = ra2;
        v.u2   = u2;
        v.want = want;
        return v;
    endfunction

    function automatic vec_t nopv(logic [7:0] want);
        return mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, want);
    endfunction

    function automatic vec_t aluv(logic [3:0] rd, logic [3:0] ra1, logic [3:0] ra2, logic [7:0] want);
        return mk(1'b0, 1'b0, rd, 1'b1, 1'b0, 1'b0, ra1, 1'b1, ra2, 1'b1, want);
    endfunction

    function automatic vec_t ldv(logic [3:0] rd, logic [3:0] ra1, logic [7:0] want);
        return mk(1'b0, 1'b0, rd, 1'b1, 1'b1, 1'b0, ra1, 1'b1, 4'd0, 1'b0, want);
    endfunction

    // Reads R7 on operand B only, writes nothing.
    function automatic vec_t readerv(logic [7:0] want);
        return mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, want);
    endfunction

    // MOV PC,Rm : writes R15, reads Rm on operand B.
    function automatic vec_t movpcv(logic [3:0] rm, logic [7:0] want);
        return mk(1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, rm, 1'b1, want);
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset        = v.rst;
        BranchTakenE = v.bt;
        RdD          = v.rd;
        RegWriteD    = v.rw;
        MemtoRegD    = v.m2r;
        PCSrcD       = v.pcs;
        RA1D         = v.ra1;
        UseA1D       = v.u1;
        RA2D         = v.ra2;
        UseA2D       = v.u2;
    endtask

    task automatic drain();
        applyStimulus(nopv(E_NONE));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        vec_t t;
        v.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, E_FLUSH));
        t = movpcv(4'd0, E_FLUSH);
        t.rst = 1'b1;
        t.bt  = 1'b1;
        v.push_back(t);
        v.push_back(nopv(E_NONE));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL reset cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
`ifdef HAZARD_FWD_EN
        v.push_back(aluv(4'd1, 4'd2, 4'd3, E_NONE));
        v.push_back(aluv(4'd2, 4'd1, 4'd3, E_NONE));
        v.push_back(aluv(4'd8, 4'd1, 4'd9, E_AM));
        v.push_back(nopv(E_AW));
`else
        v.push_back(aluv(4'd1, 4'd2, 4'd3, E_NONE));
        v.push_back(aluv(4'd2, 4'd1, 4'd3, E_STALL));
        v.push_back(aluv(4'd2, 4'd1, 4'd3, E_STALL));
        v.push_back(aluv(4'd2, 4'd1, 4'd3, E_NONE));
        v.push_back(nopv(E_NONE));
`endif
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL back_to_back cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        v.push_back(ldv(4'd4, 4'd0, E_NONE));
        v.push_back(aluv(4'd5, 4'd4, 4'd6, E_STALL));
`ifdef HAZARD_FWD_EN
        v.push_back(aluv(4'd5, 4'd4, 4'd6, E_NONE));
        v.push_back(nopv(E_AW));
`else
        v.push_back(aluv(4'd5, 4'd4, 4'd6, E_STALL));
        v.push_back(aluv(4'd5, 4'd4, 4'd6, E_NONE));
        v.push_back(nopv(E_NONE));
`endif
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL load_use cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        vec_t v[$];
        vec_t t;
        t = aluv(4'd1, 4'd2, 4'd3, E_FLUSH);
        t.bt = 1'b1;
        v.push_back(t);
        v.push_back(aluv(4'd2, 4'd1, 4'd3, E_NONE));
        v.push_back(nopv(E_NONE));
        v.push_back(ldv(4'd4, 4'd0, E_NONE));
        t = aluv(4'd5, 4'd4, 4'd6, E_ALL);
        t.bt = 1'b1;
        v.push_back(t);
        v.push_back(nopv(E_NONE));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL branch cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_pc_write();
        vec_t v[$];
        v.push_back(movpcv(4'd0, E_PCW));
        v.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 4'd0, 1'b1, E_PCW));
        v.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 4'd0, 1'b1, E_PCW));
        v.push_back(nopv(E_FD));
        v.push_back(nopv(E_NONE));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL pc_write cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_pc_with_stall();
        vec_t v[$];
        v.push_back(ldv(4'd4, 4'd0, E_NONE));
        v.push_back(movpcv(4'd4, E_ALL));
`ifdef HAZARD_FWD_EN
        v.push_back(movpcv(4'd4, E_PCW));
        v.push_back(nopv(E_PCW | E_BW));
`else
        v.push_back(movpcv(4'd4, E_ALL));
        v.push_back(movpcv(4'd4, E_PCW));
        v.push_back(nopv(E_PCW));
`endif
        v.push_back(nopv(E_PCW));
        v.push_back(nopv(E_FD));
        v.push_back(nopv(E_NONE));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL pc_with_stall cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_priority();
        vec_t v[$];
        vec_t noWr;
        noWr = aluv(4'd7, 4'd1, 4'd2, E_NONE);
        noWr.rw = 1'b0;
`ifdef HAZARD_FWD_EN
        v.push_back(aluv(4'd7, 4'd1, 4'd2, E_NONE));
        v.push_back(aluv(4'd7, 4'd1, 4'd2, E_NONE));
        v.push_back(readerv(E_NONE));
        v.push_back(nopv(E_BM));
        v.push_back(aluv(4'd7, 4'd1, 4'd2, E_NONE));
        v.push_back(noWr);
        v.push_back(readerv(E_NONE));
        v.push_back(nopv(E_BW));
`else
        v.push_back(aluv(4'd7, 4'd1, 4'd2, E_NONE));
        v.push_back(aluv(4'd7, 4'd1, 4'd2, E_NONE));
        v.push_back(readerv(E_STALL));
        v.push_back(readerv(E_STALL));
        v.push_back(readerv(E_NONE));
        v.push_back(nopv(E_NONE));
        v.push_back(aluv(4'd7, 4'd1, 4'd2, E_NONE));
        v.push_back(noWr);
        v.push_back(readerv(E_STALL));
        v.push_back(readerv(E_NONE));
        v.push_back(nopv(E_NONE));
`endif
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL priority cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        vec_t v[$];
        vec_t t;
        v.push_back(ldv(4'd4, 4'd0, E_NONE));
        v.push_back(aluv(4'd5, 4'd4, 4'd6, E_STALL));
        t = aluv(4'd5, 4'd4, 4'd6, E_FLUSH);
        t.rst = 1'b1;
        v.push_back(t);
        v.push_back(aluv(4'd5, 4'd4, 4'd6, E_NONE));
        v.push_back(nopv(E_NONE));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(negedge clk);
            checks++;
            if (obs !== v[i].want) begin
                failures++;
                $display("[TB] FAIL reset_mid_stall cyc%0d got=%h exp=%h", i, obs, v[i].want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Scenario sequence; each scenario starts from an empty shadow pipeline.
    initial begin
        applyStimulus(nopv(E_NONE));
        reset = 1'b1;
        test_reset();
        drain();
        test_back_to_back();
        drain();
        test_load_use();
        drain();
        test_branch();
        drain();
        test_pc_write();
        drain();
        test_pc_with_stall();
        drain();
        test_priority();
        drain();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
